// File: rtl/gpu_primloadseq_pkg.sv
// gpu_def: shared definitions for the primitive load sequencer.
//   - size parameter codes driven on o_loadSizeParam
//   - sequencer state encoding
//   - GP0 opcode bit positions and opcode-class decode helpers
//   - strobe bundle produced by the word planner
package gpu_def;

    // Size parameter codes (also the rect opcode bits [4:3] encoding)
    localparam logic [1:0] SIZE_VAR    = 2'd0;
    localparam logic [1:0] SIZE_1x1    = 2'd1;
    localparam logic [1:0] SIZE_8x8    = 2'd2;
    localparam logic [1:0] SIZE_16x16  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLOR,
        ST_VERTEX,
        ST_UV,
        ST_SIZE,
        ST_FILL_COORD,
        ST_FILL_SIZE,
        ST_EMIT
    } state_t;

    // Opcode bit positions
    localparam int OP_GOURAUD_BIT = 4;   // polygon only
    localparam int OP_QUAD_BIT    = 3;   // polygon only
    localparam int OP_TEX_BIT     = 2;   // polygon and rect
    localparam int OP_SIZE_LSB    = 3;   // rect size code is bits [4:3]

    localparam logic [7:0] OP_FILL = 8'h02;

    typedef struct packed {
        logic       load_vertices;
        logic       load_uv;
        logic       load_rgb;
        logic       load_all_rgb;
        logic       load_coord1;
        logic       load_size;
        logic       load_rect_edge;
        logic       is_vertex_load_state;
        logic [1:0] size_param;
        logic [1:0] target_vertex;
    } strobe_t;

    function automatic logic is_poly(input logic [7:0] op);
        return op[7:5] == 3'b001;
    endfunction

    function automatic logic is_rect(input logic [7:0] op);
        return op[7:5] == 3'b011;
    endfunction

endpackage

// File: rtl/gpu_primloadseq_wordplan.sv
// gpu_primWordPlan: purely combinational word planner.
// Given the current state, the effective opcode and the vertex counter it
// returns the state/counter to move to on the next advance event (a word pop,
// or an accept while in EMIT) and the strobe set that goes with a pop in the
// current state. The caller gates the strobes with the actual pop.
//   i_state       current sequencer state
//   i_opcode      opcode in effect (head word while IDLE, latched otherwise)
//   i_vc          vertex counter 0..3
//   o_nextState   state after the advance event
//   o_nextVc      vertex counter after the advance event
//   o_strobe      register-file strobes for a pop in i_state
//   o_unsupported opcode in IDLE is not a recognised command
module gpu_primWordPlan
    import gpu_def::*;
(
    input  state_t      i_state,
    input  logic [7:0]  i_opcode,
    input  logic [1:0]  i_vc,
    output state_t      o_nextState,
    output logic [1:0]  o_nextVc,
    output strobe_t     o_strobe,
    output logic        o_unsupported
);

    logic       w_poly;
    logic       w_rect;
    logic       w_fill;
    logic       w_gouraud;
    logic       w_quad;
    logic       w_tex;
    logic [1:0] w_sizeCode;
    logic [1:0] w_slot;
    state_t     w_vtxDoneState;
    logic [1:0] w_vtxDoneVc;

    assign w_poly     = is_poly(i_opcode);
    assign w_rect     = is_rect(i_opcode);
    assign w_fill     = (i_opcode == OP_FILL);
    assign w_gouraud  = i_opcode[OP_GOURAUD_BIT];
    assign w_quad     = i_opcode[OP_QUAD_BIT];
    assign w_tex      = i_opcode[OP_TEX_BIT];
    assign w_sizeCode = i_opcode[OP_SIZE_LSB +: 2];

    // Vertex 3 of a quad reuses slot 0, forming triangle (v3,v1,v2)
    assign w_slot = (i_vc == 2'd3) ? 2'd0 : i_vc;

    // Polygon vertex finished (after VERTEX, or after UV when textured).
    // vc==3 means vertex 3 just finished: clear vc so the following EMIT
    // returns to IDLE instead of asking for v3 again.
    always_comb begin
        w_vtxDoneState = ST_EMIT;
        w_vtxDoneVc    = i_vc;
        if (i_vc == 2'd3) begin
            w_vtxDoneVc = 2'd0;
        end else if (i_vc == 2'd2) begin
            w_vtxDoneVc = 2'd3;
        end else begin
            w_vtxDoneVc    = i_vc + 2'd1;
            w_vtxDoneState = w_gouraud ? ST_COLOR : ST_VERTEX;
        end
    end

    always_comb begin
        o_nextState   = i_state;
        o_nextVc      = i_vc;
        o_strobe      = '0;
        o_unsupported = 1'b0;
        case (i_state)
            ST_IDLE: begin
                o_nextVc = 2'd0;
                if (w_poly) begin
                    o_strobe.load_rgb     = 1'b1;
                    o_strobe.load_all_rgb = ~w_gouraud;
                    o_nextState           = ST_VERTEX;
                end else if (w_rect) begin
                    o_strobe.load_rgb     = 1'b1;
                    o_strobe.load_all_rgb = 1'b1;
                    o_nextState           = ST_VERTEX;
                end else if (w_fill) begin
                    o_strobe.load_rgb     = 1'b1;
                    o_strobe.load_all_rgb = 1'b1;
                    o_nextState           = ST_FILL_COORD;
                end else begin
                    o_unsupported = 1'b1;
                    o_nextState   = ST_IDLE;
                end
            end
            ST_COLOR: begin
                o_strobe.load_rgb      = 1'b1;
                o_strobe.target_vertex = w_slot;
                o_nextState            = ST_VERTEX;
            end
            ST_VERTEX: begin
                o_strobe.load_vertices = 1'b1;
                if (w_rect) begin
                    // Fixed-size rects carry their size in the opcode, so
                    // the size load rides along with the vertex word.
                    if (w_sizeCode != SIZE_VAR) begin
                        o_strobe.load_size            = 1'b1;
                        o_strobe.load_rect_edge       = 1'b1;
                        o_strobe.is_vertex_load_state = 1'b1;
                        o_strobe.size_param           = w_sizeCode;
                    end
                    if (w_tex)
                        o_nextState = ST_UV;
                    else
                        o_nextState = (w_sizeCode == SIZE_VAR) ? ST_SIZE : ST_EMIT;
                end else begin
                    o_strobe.target_vertex = w_slot;
                    if (w_tex) begin
                        o_nextState = ST_UV;
                    end else begin
                        o_nextState = w_vtxDoneState;
                        o_nextVc    = w_vtxDoneVc;
                    end
                end
            end
            ST_UV: begin
                o_strobe.load_uv = 1'b1;
                if (w_rect) begin
                    o_nextState = (w_sizeCode == SIZE_VAR) ? ST_SIZE : ST_EMIT;
                end else begin
                    o_strobe.target_vertex = w_slot;
                    o_nextState            = w_vtxDoneState;
                    o_nextVc               = w_vtxDoneVc;
                end
            end
            ST_SIZE: begin
                o_strobe.load_size      = 1'b1;
                o_strobe.load_rect_edge = 1'b1;
                o_strobe.size_param     = SIZE_VAR;
                o_nextState             = ST_EMIT;
            end
            ST_FILL_COORD: begin
                o_strobe.load_coord1 = 1'b1;
                o_nextState          = ST_FILL_SIZE;
            end
            ST_FILL_SIZE: begin
                o_strobe.load_size  = 1'b1;
                o_strobe.size_param = SIZE_VAR;
                o_nextState         = ST_EMIT;
            end
            ST_EMIT: begin
                // Taken only on accept: a quad with vc==3 still owes vertex 3
                if (w_poly && w_quad && (i_vc == 2'd3)) begin
                    o_nextState = w_gouraud ? ST_COLOR : ST_VERTEX;
                end else begin
                    o_nextState = ST_IDLE;
                    o_nextVc    = 2'd0;
                end
            end
            default: begin
                o_nextState = ST_IDLE;
                o_nextVc    = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/gpu_primloadseq.sv
// gpu_primloadseq: GP0 command-word sequencer feeding the primitive register
// file. Pops polygon / rectangle / fill command words from the command FIFO,
// drives per-word load strobes, then offers the finished primitive to the
// rasterizer with a valid/accept handshake. Unknown opcodes are popped and
// flagged with a one-cycle o_unsupported pulse.
//   i_clk, i_nRst         clock, asynchronous active-low reset
//   i_fifoValid/Data      FIFO head word (data also goes straight to the RF)
//   o_fifoPop/validData   pop this cycle / RF write qualifier (identical)
//   o_command             head opcode in IDLE, latched opcode otherwise
//   o_targetVertex        vertex slot 0..2
//   o_load*, o_isVertexLoadState, o_loadSizeParam   RF strobes
//   o_primValid/i_primAccept   primitive handshake to the rasterizer
//   o_unsupported         pulse after an unsupported opcode was dropped
module gpu_primloadseq
    import gpu_def::*;
(
    input  logic        i_clk,
    input  logic        i_nRst,
    input  logic        i_fifoValid,
    input  logic [31:0] i_fifoData,
    output logic        o_fifoPop,
    output logic        o_validData,
    output logic [7:0]  o_command,
    output logic [1:0]  o_targetVertex,
    output logic        o_loadVertices,
    output logic        o_loadUV,
    output logic        o_loadRGB,
    output logic        o_loadAllRGB,
    output logic        o_loadCoord1,
    output logic        o_loadSize,
    output logic        o_loadRectEdge,
    output logic        o_isVertexLoadState,
    output logic [1:0]  o_loadSizeParam,
    output logic        o_primValid,
    input  logic        i_primAccept,
    output logic        o_unsupported
);

    state_t     r_state;
    logic [1:0] r_vc;
    logic [7:0] r_opcode;
    logic       r_primValid;
    logic       r_unsupported;

    logic [7:0] w_opcode;
    state_t     w_planState;
    logic [1:0] w_planVc;
    strobe_t    w_planStrobe;
    logic       w_planUnsup;
    logic       w_pop;
    logic       w_accept;
    logic       w_advance;
    state_t     w_stateNext;
    logic [1:0] w_vcNext;
    strobe_t    w_strobe;
    logic       w_unusedData;

    // The payload bits are consumed by the register file, not here
    assign w_unusedData = ^i_fifoData[23:0];

    assign w_opcode = (r_state == ST_IDLE) ? i_fifoData[31:24] : r_opcode;

    gpu_primWordPlan u_plan (
        .i_state       (r_state),
        .i_opcode      (w_opcode),
        .i_vc          (r_vc),
        .o_nextState   (w_planState),
        .o_nextVc      (w_planVc),
        .o_strobe      (w_planStrobe),
        .o_unsupported (w_planUnsup)
    );

    // Every state except EMIT consumes a word; i_nRst in the term forces
    // all strobes low combinationally while reset is held.
    assign w_pop       = i_nRst & i_fifoValid & (r_state != ST_EMIT);
    assign w_accept    = (r_state == ST_EMIT) & i_primAccept;
    assign w_advance   = w_pop | w_accept;
    assign w_stateNext = w_advance ? w_planState : r_state;
    assign w_vcNext    = w_advance ? w_planVc : r_vc;
    assign w_strobe    = w_pop ? w_planStrobe : '0;

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_state       <= ST_IDLE;
            r_vc          <= 2'd0;
            r_opcode      <= 8'h00;
            r_primValid   <= 1'b0;
            r_unsupported <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_vc          <= w_vcNext;
            r_primValid   <= (w_stateNext == ST_EMIT);
            r_unsupported <= w_pop & w_planUnsup;
            if (w_pop && (r_state == ST_IDLE))
                r_opcode <= i_fifoData[31:24];
        end
    end

    assign o_fifoPop           = w_pop;
    assign o_validData         = w_pop;
    assign o_command           = w_opcode;
    assign o_targetVertex      = w_strobe.target_vertex;
    assign o_loadVertices      = w_strobe.load_vertices;
    assign o_loadUV            = w_strobe.load_uv;
    assign o_loadRGB           = w_strobe.load_rgb;
    assign o_loadAllRGB        = w_strobe.load_all_rgb;
    assign o_loadCoord1        = w_strobe.load_coord1;
    assign o_loadSize          = w_strobe.load_size;
    assign o_loadRectEdge      = w_strobe.load_rect_edge;
    assign o_isVertexLoadState = w_strobe.is_vertex_load_state;
    assign o_loadSizeParam     = w_strobe.size_param;
    assign o_primValid         = r_primValid;
    assign o_unsupported       = r_unsupported;

endmodule

// File: tb/tb_gpu_primloadseq.sv
// Directed testbench for gpu_primloadseq. Strobes are packed as
// {vert, uv, rgb, allrgb, coord1, size, rectedge, vtxstate, param[1:0], slot[1:0]}.
module tb_gpu_primloadseq;

    logic        i_clk = 1'b0;
    logic        i_nRst = 1'b0;
    logic        i_fifoValid = 1'b0;
    logic [31:0] i_fifoData = 32'h0;
    logic        i_primAccept = 1'b0;
    logic        o_fifoPop, o_validData;
    logic [7:0]  o_command;
    logic [1:0]  o_targetVertex, o_loadSizeParam;
    logic        o_loadVertices, o_loadUV, o_loadRGB, o_loadAllRGB, o_loadCoord1;
    logic        o_loadSize, o_loadRectEdge, o_isVertexLoadState;
    logic        o_primValid, o_unsupported;

    int checks = 0;
    int failures = 0;

    localparam logic [11:0] S_V   = 12'h800;
    localparam logic [11:0] S_UV  = 12'h400;
    localparam logic [11:0] S_RGB = 12'h200;
    localparam logic [11:0] S_ALL = 12'h100;
    localparam logic [11:0] S_C1  = 12'h080;
    localparam logic [11:0] S_SZ  = 12'h040;
    localparam logic [11:0] S_RE  = 12'h020;
    localparam logic [11:0] S_VLS = 12'h010;
    localparam logic [11:0] S_P8  = 12'h008;  // SIZE_8x8 in param field

    logic [11:0] w_str;
    assign w_str = {o_loadVertices, o_loadUV, o_loadRGB, o_loadAllRGB, o_loadCoord1,
                    o_loadSize, o_loadRectEdge, o_isVertexLoadState,
                    o_loadSizeParam, o_targetVertex};

    gpu_primloadseq dut (
        .i_clk               (i_clk),
        .i_nRst              (i_nRst),
        .i_fifoValid         (i_fifoValid),
        .i_fifoData          (i_fifoData),
        .o_fifoPop           (o_fifoPop),
        .o_validData         (o_validData),
        .o_command           (o_command),
        .o_targetVertex      (o_targetVertex),
        .o_loadVertices      (o_loadVertices),
        .o_loadUV            (o_loadUV),
        .o_loadRGB           (o_loadRGB),
        .o_loadAllRGB        (o_loadAllRGB),
        .o_loadCoord1        (o_loadCoord1),
        .o_loadSize          (o_loadSize),
        .o_loadRectEdge      (o_loadRectEdge),
        .o_isVertexLoadState (o_isVertexLoadState),
        .o_loadSizeParam     (o_loadSizeParam),
        .o_primValid         (o_primValid),
        .i_primAccept        (i_primAccept),
        .o_unsupported       (o_unsupported)
    );

    always #5 i_clk = ~i_clk;

    // Offer one word and capture what the DUT shows in the cycle it pops it.
    // Entered and left at posedge+1; ok=0 if no pop within the budget.
    task automatic feed(input logic [31:0] w, output logic [11:0] s, output logic [7:0] c,
                        output logic vd, output logic pv, output bit ok);
        ok = 0; s = '0; c = '0; vd = 0; pv = 0;
        i_fifoData  = w;
        i_fifoValid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge i_clk);
            if (o_fifoPop === 1'b1) begin
                ok = 1; s = w_str; c = o_command; vd = o_validData; pv = o_primValid;
            end
            @(posedge i_clk); #1;
        end
        i_fifoValid = 1'b0;
    endtask

    // Pulse accept for one cycle; capture o_primValid in that cycle and the next.
    task automatic accept_capture(output logic pv_at, output logic pv_after);
        i_fifoValid  = 1'b0;
        i_primAccept = 1'b1;
        @(negedge i_clk); pv_at = o_primValid;
        @(posedge i_clk); #1;
        i_primAccept = 1'b0;
        @(negedge i_clk); pv_after = o_primValid;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_nRst = 1'b0;
        i_fifoValid = 1'b1;
        i_fifoData = 32'h20FF0000;
        @(posedge i_clk); @(negedge i_clk);
        checks++;
        if (o_fifoPop !== 1'b0 || o_validData !== 1'b0 || w_str !== 12'h0 ||
            o_primValid !== 1'b0 || o_unsupported !== 1'b0 || o_command !== 8'h20) begin
            failures++;
            $display("FAIL reset got pop=%b vd=%b str=%h pv=%b uns=%b cmd=%h want 0 0 000 0 0 20",
                     o_fifoPop, o_validData, w_str, o_primValid, o_unsupported, o_command);
        end
        $display("reset: pop=%b str=%h pv=%b", o_fifoPop, w_str, o_primValid);
        @(posedge i_clk); #1;
        i_fifoValid = 1'b0;
        i_nRst = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_flat_tri();
        logic [31:0] words[4] = '{32'h20FF0000, 32'h0014000A, 32'h0028001E, 32'h00050032};
        logic [11:0] exp_s[4] = '{S_RGB | S_ALL, S_V, S_V | 12'd1, S_V | 12'd2};
        logic [11:0] s; logic [7:0] c; logic vd, pv, pa, pb; bit ok;
        for (int i = 0; i < 4; i++) begin
            feed(words[i], s, c, vd, pv, ok);
            checks++;
            if (!ok || s !== exp_s[i] || vd !== 1'b1 || pv !== 1'b0 || c !== 8'h20) begin
                failures++;
                $display("FAIL flat_pop%0d got ok=%0d str=%h vd=%b pv=%b cmd=%h want str=%h vd=1 pv=0 cmd=20",
                         i, ok, s, vd, pv, c, exp_s[i]);
            end
            $display("flat pop%0d: str=%h cmd=%h", i, s, c);
        end
        // Words available during EMIT must not be popped
        i_fifoValid = 1'b1;
        i_fifoData  = 32'h02000000;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_primValid !== 1'b1 || o_fifoPop !== 1'b0) begin
                failures++;
                $display("FAIL flat_hold%0d got pv=%b pop=%b want pv=1 pop=0", k, o_primValid, o_fifoPop);
            end
            @(posedge i_clk); #1;
        end
        accept_capture(pa, pb);
        checks++;
        if (pa !== 1'b1 || pb !== 1'b0) begin
            failures++;
            $display("FAIL flat_accept got pv_at=%b pv_after=%b want 1 0", pa, pb);
        end
        $display("flat accept: pv_at=%b pv_after=%b", pa, pb);
    endtask

    // Gouraud textured quad 0x3C; gap=1 inserts an invalid cycle before each word
    task automatic run_quad(input bit gap, input string tag);
        logic [31:0] words[12] = '{32'h3C0000FF, 32'h0014000A, 32'h00001010, 32'h0000FF00,
                                   32'h0028001E, 32'h00002020, 32'h00FF0000, 32'h00050032,
                                   32'h00003030, 32'h00123456, 32'h003C0046, 32'h00004040};
        logic [11:0] exp_s[12] = '{S_RGB, S_V, S_UV,
                                   S_RGB | 12'd1, S_V | 12'd1, S_UV | 12'd1,
                                   S_RGB | 12'd2, S_V | 12'd2, S_UV | 12'd2,
                                   S_RGB, S_V, S_UV};
        logic [11:0] s; logic [7:0] c; logic vd, pv, pa, pb; bit ok;
        for (int i = 0; i < 12; i++) begin
            if (gap) begin
                i_fifoValid = 1'b0;
                i_fifoData  = words[i];
                @(negedge i_clk);
                checks++;
                if (o_fifoPop !== 1'b0 || o_validData !== 1'b0 || w_str !== 12'h0) begin
                    failures++;
                    $display("FAIL %s_gap%0d got pop=%b vd=%b str=%h want 0 0 000", tag, i, o_fifoPop, o_validData, w_str);
                end
                @(posedge i_clk); #1;
            end
            feed(words[i], s, c, vd, pv, ok);
            checks++;
            if (!ok || s !== exp_s[i] || vd !== 1'b1 || pv !== 1'b0 || c !== 8'h3C) begin
                failures++;
                $display("FAIL %s_pop%0d got ok=%0d str=%h vd=%b pv=%b cmd=%h want str=%h vd=1 pv=0 cmd=3c",
                         tag, i, ok, s, vd, pv, c, exp_s[i]);
            end
            $display("%s pop%0d: str=%h", tag, i, s);
            if (i == 8 || i == 11) begin
                accept_capture(pa, pb);
                checks++;
                if (pa !== 1'b1 || pb !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_emit%0d got pv_at=%b pv_after=%b want 1 0", tag, i, pa, pb);
                end
                $display("%s emit after pop%0d: pv_at=%b pv_after=%b", tag, i, pa, pb);
            end
        end
        // Back in IDLE: o_command follows the head word again
        i_fifoData = 32'hA5000000;
        #1;
        checks++;
        if (o_command !== 8'hA5) begin
            failures++;
            $display("FAIL %s_idle got cmd=%h want a5", tag, o_command);
        end
    endtask

    task automatic test_gouraud_quad();
        run_quad(1'b0, "quad");
    endtask

    task automatic test_gap_quad();
        run_quad(1'b1, "gapquad");
    endtask

    task automatic test_rect_fixed();
        logic [31:0] words[3] = '{32'h74808080, 32'h00320064, 32'h00001020};
        logic [11:0] exp_s[3] = '{S_RGB | S_ALL, S_V | S_SZ | S_RE | S_VLS | S_P8, S_UV};
        logic [11:0] s; logic [7:0] c; logic vd, pv, pa, pb; bit ok;
        for (int i = 0; i < 3; i++) begin
            feed(words[i], s, c, vd, pv, ok);
            checks++;
            if (!ok || s !== exp_s[i] || c !== 8'h74) begin
                failures++;
                $display("FAIL rect8_pop%0d got ok=%0d str=%h cmd=%h want str=%h cmd=74", i, ok, s, c, exp_s[i]);
            end
            $display("rect8 pop%0d: str=%h", i, s);
        end
        accept_capture(pa, pb);
        checks++;
        if (pa !== 1'b1 || pb !== 1'b0) begin
            failures++;
            $display("FAIL rect8_emit got pv_at=%b pv_after=%b want 1 0", pa, pb);
        end
    endtask

    task automatic test_rect_var_fill();
        logic [31:0] words[6] = '{32'h60112233, 32'h00320064, 32'h00100020,
                                  32'h02445566, 32'h00080010, 32'h00400080};
        logic [11:0] exp_s[6] = '{S_RGB | S_ALL, S_V, S_SZ | S_RE,
                                  S_RGB | S_ALL, S_C1, S_SZ};
        logic [7:0]  exp_c[6] = '{8'h60, 8'h60, 8'h60, 8'h02, 8'h02, 8'h02};
        logic [11:0] s; logic [7:0] c; logic vd, pv, pa, pb; bit ok;
        for (int i = 0; i < 6; i++) begin
            feed(words[i], s, c, vd, pv, ok);
            checks++;
            if (!ok || s !== exp_s[i] || c !== exp_c[i]) begin
                failures++;
                $display("FAIL varfill_pop%0d got ok=%0d str=%h cmd=%h want str=%h cmd=%h",
                         i, ok, s, c, exp_s[i], exp_c[i]);
            end
            $display("varfill pop%0d: str=%h cmd=%h", i, s, c);
            if (i == 2 || i == 5) begin
                accept_capture(pa, pb);
                checks++;
                if (pa !== 1'b1 || pb !== 1'b0) begin
                    failures++;
                    $display("FAIL varfill_emit%0d got pv_at=%b pv_after=%b want 1 0", i, pa, pb);
                end
            end
        end
    endtask

    task automatic test_unsupported();
        logic [11:0] s; logic [7:0] c; logic vd, pv; bit ok;
        feed(32'hE1000000, s, c, vd, pv, ok);
        checks++;
        if (!ok || s !== 12'h0 || vd !== 1'b1) begin
            failures++;
            $display("FAIL unsup_pop got ok=%0d str=%h vd=%b want ok=1 str=000 vd=1", ok, s, vd);
        end
        @(negedge i_clk);
        checks++;
        if (o_unsupported !== 1'b1 || o_primValid !== 1'b0) begin
            failures++;
            $display("FAIL unsup_pulse got uns=%b pv=%b want 1 0", o_unsupported, o_primValid);
        end
        @(posedge i_clk); #1;
        i_fifoData = 32'h5A000000;
        @(negedge i_clk);
        checks++;
        if (o_unsupported !== 1'b0 || o_command !== 8'h5A) begin
            failures++;
            $display("FAIL unsup_after got uns=%b cmd=%h want 0 5a", o_unsupported, o_command);
        end
        $display("unsupported: pulse checked, cmd now %h", o_command);
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [11:0] s; logic [7:0] c; logic vd, pv, pa, pb; bit ok;
        logic [31:0] words[3] = '{32'h02778899, 32'h00100010, 32'h00200020};
        logic [11:0] exp_s[3] = '{S_RGB | S_ALL, S_C1, S_SZ};
        feed(32'h3000FF00, s, c, vd, pv, ok);   // gouraud triangle
        feed(32'h0014000A, s, c, vd, pv, ok);
        // Third word (colour of vertex 1) is being offered
        i_fifoData  = 32'h0000FF00;
        i_fifoValid = 1'b1;
        #1;
        checks++;
        if (o_fifoPop !== 1'b1 || w_str !== (S_RGB | 12'd1)) begin
            failures++;
            $display("FAIL rstmid_pre got pop=%b str=%h want 1 %h", o_fifoPop, w_str, S_RGB | 12'd1);
        end
        i_nRst = 1'b0;
        #1;
        checks++;
        if (o_fifoPop !== 1'b0 || o_validData !== 1'b0 || w_str !== 12'h0 || o_primValid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in got pop=%b vd=%b str=%h pv=%b want 0 0 000 0",
                     o_fifoPop, o_validData, w_str, o_primValid);
        end
        $display("reset mid-polygon: pop=%b str=%h", o_fifoPop, w_str);
        @(posedge i_clk); #1;
        i_nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            feed(words[i], s, c, vd, pv, ok);
            checks++;
            if (!ok || s !== exp_s[i] || c !== 8'h02) begin
                failures++;
                $display("FAIL rstmid_pop%0d got ok=%0d str=%h cmd=%h want str=%h cmd=02", i, ok, s, c, exp_s[i]);
            end
        end
        accept_capture(pa, pb);
        checks++;
        if (pa !== 1'b1 || pb !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_emit got pv_at=%b pv_after=%b want 1 0", pa, pb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flat_tri();
        test_gouraud_quad();
        test_rect_fixed();
        test_rect_var_fill();
        test_gap_quad();
        test_unsupported();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
